// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if
// Bundles the requester handshakes, the adder operand/result bus and the status
// outputs of adder_share_arbiter.
//   slave  : arbiter side (takes requests and add_out, drives grants/operands/responses)
//   master : environment side (requesters plus adder)
// Signals:
//   req0_valid/req0_a/req0_b/req0_ready : requester 0 handshake and operands
//   req1_valid/req1_a/req1_b/req1_ready : requester 1 handshake and operands
//   add_in1/add_in2                     : steered operands to the adder
//   add_out                             : adder result
//   rsp0_valid/rsp1_valid/rsp_data      : one-cycle response strobes and sum
//   busy/stall_cnt                      : in-flight flag and saturating stall count
interface adder_share_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic [31:0] add_in1;
    logic [31:0] add_in2;
    logic [31:0] add_out;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] stall_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_out,
        output req0_ready, req1_ready, add_in1, add_in2, rsp0_valid, rsp1_valid,
               rsp_data, busy, stall_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, add_out,
        input  req0_ready, req1_ready, add_in1, add_in2, rsp0_valid, rsp1_valid,
               rsp_data, busy, stall_cnt
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Round-robin sharing of one pipelined 32-bit adder between two requesters.
// Grants at most one request per cycle, steers its operands onto the adder,
// tracks the operation through a tag pipeline matched to the adder latency and
// returns the sum with a one-cycle strobe to the winner.
// Parameters:
//   LATENCY : cycles from issue edge to valid add_out, legal 1..4
// Ports:
//   clk   : rising-edge clock shared with the adder
//   rst_n : asynchronous active-low reset
//   bus   : adder_share_arbiter_if.slave (requests, adder bus, responses, status)
module adder_share_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    adder_share_arbiter_if.slave bus
);

    logic               last_grant_q;
    logic               last_grant_d;
    logic [LATENCY-1:0] tag_vld_q;
    logic [LATENCY-1:0] tag_vld_d;
    logic [LATENCY-1:0] tag_id_q;
    logic [LATENCY-1:0] tag_id_d;
    logic [15:0]        stall_q;
    logic [15:0]        stall_d;

    logic               grant0;
    logic               grant1;
    logic               xfer;
    logic               stall;
    logic [LATENCY:0]   vld_chain;
    logic [LATENCY:0]   id_chain;

    // Contested cycles go to whoever did not win the last transfer. Gating with
    // rst_n keeps grants and operands quiet while reset is held.
    always_comb begin
        grant0 = rst_n & bus.req0_valid & (~bus.req1_valid | last_grant_q);
        grant1 = rst_n & bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        xfer   = grant0 | grant1;
        stall  = (bus.req0_valid & ~grant0) | (bus.req1_valid & ~grant1);
    end

    always_comb begin
        bus.add_in1 = 32'h0;
        bus.add_in2 = 32'h0;
        if (grant0) begin
            bus.add_in1 = bus.req0_a;
            bus.add_in2 = bus.req0_b;
        end else if (grant1) begin
            bus.add_in1 = bus.req1_a;
            bus.add_in2 = bus.req1_b;
        end
    end

    // Stage 0 takes the current issue; the chain trick keeps LATENCY=1 legal.
    assign vld_chain = {tag_vld_q, xfer};
    assign id_chain  = {tag_id_q, grant1};

    always_comb begin
        last_grant_d = last_grant_q;
        if (xfer) begin
            last_grant_d = grant1;
        end
        tag_vld_d = vld_chain[LATENCY-1:0];
        tag_id_d  = id_chain[LATENCY-1:0];
        stall_d   = stall_q;
        if (stall && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            stall_q      <= 16'h0;
        end else begin
            last_grant_q <= last_grant_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp0_valid = tag_vld_q[LATENCY-1] & ~tag_id_q[LATENCY-1];
    assign bus.rsp1_valid = tag_vld_q[LATENCY-1] & tag_id_q[LATENCY-1];
    assign bus.rsp_data   = bus.add_out;
    assign bus.busy       = |tag_vld_q;
    assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: one LATENCY=1 and one LATENCY=3 instance,
// each driven through its own interface with a behavioural pipelined adder.
module tb_adder_share_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    adder_share_arbiter_if if1 ();
    adder_share_arbiter_if if3 ();

    adder_share_arbiter #(.LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    adder_share_arbiter #(.LATENCY(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3.slave)
    );

    // Adder models: registered inputs, result LATENCY cycles after the issue edge.
    logic [31:0] p3_0;
    logic [31:0] p3_1;
    always @(posedge clk) begin
        if1.add_out <= if1.add_in1 + if1.add_in2;
        p3_0        <= if3.add_in1 + if3.add_in2;
        p3_1        <= p3_0;
        if3.add_out <= p3_1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    logic [7:0] exp_rdy3;
    logic [7:0] exp_rsp3;
    logic [7:0] exp_busy3;

    initial begin
        rst_n          = 1'b0;
        if1.req0_valid = 1'b1;
        if1.req0_a     = 32'd10;
        if1.req0_b     = 32'd1;
        if1.req1_valid = 1'b1;
        if1.req1_a     = 32'd20;
        if1.req1_b     = 32'd2;
        if3.req0_valid = 1'b0;
        if3.req0_a     = 32'h0;
        if3.req0_b     = 32'h0;
        if3.req1_valid = 1'b0;
        if3.req1_a     = 32'h0;
        if3.req1_b     = 32'h0;

        // Reset: grants and operands forced low despite valid requests.
        next();
        #1;
        chk("rst_ready0", {31'h0, if1.req0_ready}, 32'h0);
        chk("rst_ready1", {31'h0, if1.req1_ready}, 32'h0);
        chk("rst_add_in1", if1.add_in1, 32'h0);
        chk("rst_add_in2", if1.add_in2, 32'h0);
        chk("rst_busy", {31'h0, if1.busy}, 32'h0);
        chk("rst_rsp0", {31'h0, if1.rsp0_valid}, 32'h0);
        chk("rst_stall", {16'h0, if1.stall_cnt}, 32'h0);
        chk("rst_busy3", {31'h0, if3.busy}, 32'h0);

        // Contention from reset: grants 0,1,0,1 with responses one cycle later.
        next();
        rst_n = 1'b1;
        #1;
        chk("c0_ready0", {31'h0, if1.req0_ready}, 32'h1);
        chk("c0_ready1", {31'h0, if1.req1_ready}, 32'h0);
        chk("c0_add_in1", if1.add_in1, 32'd10);
        chk("c0_add_in2", if1.add_in2, 32'd1);
        next();
        if1.req0_a = 32'd30;
        if1.req0_b = 32'd3;
        #1;
        chk("c1_ready1", {31'h0, if1.req1_ready}, 32'h1);
        chk("c1_ready0", {31'h0, if1.req0_ready}, 32'h0);
        chk("c1_add_in1", if1.add_in1, 32'd20);
        chk("c1_rsp0", {31'h0, if1.rsp0_valid}, 32'h1);
        chk("c1_rsp1", {31'h0, if1.rsp1_valid}, 32'h0);
        chk("c1_data", if1.rsp_data, 32'd11);
        chk("c1_stall", {16'h0, if1.stall_cnt}, 32'd1);
        next();
        if1.req1_a = 32'd40;
        if1.req1_b = 32'd4;
        #1;
        chk("c2_ready0", {31'h0, if1.req0_ready}, 32'h1);
        chk("c2_add_in1", if1.add_in1, 32'd30);
        chk("c2_rsp1", {31'h0, if1.rsp1_valid}, 32'h1);
        chk("c2_data", if1.rsp_data, 32'd22);
        chk("c2_stall", {16'h0, if1.stall_cnt}, 32'd2);
        next();
        if1.req0_a = 32'd50;
        if1.req0_b = 32'd5;
        #1;
        chk("c3_ready1", {31'h0, if1.req1_ready}, 32'h1);
        chk("c3_add_in1", if1.add_in1, 32'd40);
        chk("c3_rsp0", {31'h0, if1.rsp0_valid}, 32'h1);
        chk("c3_data", if1.rsp_data, 32'd33);
        chk("c3_stall", {16'h0, if1.stall_cnt}, 32'd3);
        next();
        if1.req0_valid = 1'b0;
        if1.req1_valid = 1'b0;
        #1;
        chk("c4_ready0_idle", {31'h0, if1.req0_ready}, 32'h0);
        chk("c4_ready1_idle", {31'h0, if1.req1_ready}, 32'h0);
        chk("c4_add_in1_idle", if1.add_in1, 32'h0);
        chk("c4_rsp1", {31'h0, if1.rsp1_valid}, 32'h1);
        chk("c4_data", if1.rsp_data, 32'd44);
        chk("c4_stall", {16'h0, if1.stall_cnt}, 32'd4);
        next();
        #1;
        chk("c5_rsp0", {31'h0, if1.rsp0_valid}, 32'h0);
        chk("c5_rsp1", {31'h0, if1.rsp1_valid}, 32'h0);
        chk("c5_busy", {31'h0, if1.busy}, 32'h0);
        chk("c5_stall", {16'h0, if1.stall_cnt}, 32'd4);

        // Single request on requester 0.
        next();
        if1.req0_valid = 1'b1;
        if1.req0_a     = 32'h0000_1000;
        if1.req0_b     = 32'h0000_0004;
        #1;
        chk("s_ready0", {31'h0, if1.req0_ready}, 32'h1);
        chk("s_add_in1", if1.add_in1, 32'h0000_1000);
        chk("s_add_in2", if1.add_in2, 32'h0000_0004);
        chk("s_busy_issue", {31'h0, if1.busy}, 32'h0);
        next();
        if1.req0_valid = 1'b0;
        #1;
        chk("s_rsp0", {31'h0, if1.rsp0_valid}, 32'h1);
        chk("s_rsp1", {31'h0, if1.rsp1_valid}, 32'h0);
        chk("s_data", if1.rsp_data, 32'h0000_1004);
        chk("s_busy", {31'h0, if1.busy}, 32'h1);
        chk("s_stall", {16'h0, if1.stall_cnt}, 32'd4);
        next();
        #1;
        chk("s_rsp0_after", {31'h0, if1.rsp0_valid}, 32'h0);
        chk("s_busy_after", {31'h0, if1.busy}, 32'h0);

        // Modulo-2^32 wrap on requester 1.
        next();
        if1.req1_valid = 1'b1;
        if1.req1_a     = 32'hFFFF_FFFF;
        if1.req1_b     = 32'h0000_0002;
        #1;
        chk("w_ready1", {31'h0, if1.req1_ready}, 32'h1);
        next();
        if1.req1_valid = 1'b0;
        #1;
        chk("w_rsp1", {31'h0, if1.rsp1_valid}, 32'h1);
        chk("w_rsp0", {31'h0, if1.rsp0_valid}, 32'h0);
        chk("w_data", if1.rsp_data, 32'h0000_0001);

        // LATENCY=3: issues in cycles 0,1,2 -> responses 3,4,5, busy 1..5.
        exp_rdy3  = 8'b0000_0111;
        exp_rsp3  = 8'b0011_1000;
        exp_busy3 = 8'b0011_1110;
        for (int i = 0; i < 8; i++) begin
            next();
            if3.req1_valid = (i < 3);
            if3.req1_a     = 32'd100 * (i + 1);
            if3.req1_b     = i + 1;
            #1;
            chk($sformatf("l3_ready1_c%0d", i), {31'h0, if3.req1_ready}, {31'h0, exp_rdy3[i]});
            chk($sformatf("l3_rsp1_c%0d", i), {31'h0, if3.rsp1_valid}, {31'h0, exp_rsp3[i]});
            chk($sformatf("l3_rsp0_c%0d", i), {31'h0, if3.rsp0_valid}, 32'h0);
            chk($sformatf("l3_busy_c%0d", i), {31'h0, if3.busy}, {31'h0, exp_busy3[i]});
            if (exp_rsp3[i]) begin
                chk($sformatf("l3_data_c%0d", i), if3.rsp_data, 32'd101 * (i - 2));
            end
        end

        // Reset while an op is in flight: it must never respond.
        next();
        if1.req0_valid = 1'b1;
        if1.req0_a     = 32'd7;
        if1.req0_b     = 32'd8;
        #1;
        chk("m_ready0", {31'h0, if1.req0_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("m_busy_inflight", {31'h0, if1.busy}, 32'h1);
        rst_n          = 1'b0;
        if1.req0_valid = 1'b0;
        #1;
        chk("m_busy_rst", {31'h0, if1.busy}, 32'h0);
        chk("m_rsp0_rst", {31'h0, if1.rsp0_valid}, 32'h0);
        next();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("m_rsp0_c%0d", i), {31'h0, if1.rsp0_valid}, 32'h0);
            chk($sformatf("m_rsp1_c%0d", i), {31'h0, if1.rsp1_valid}, 32'h0);
            next();
        end
        #1;
        chk("m_stall_cleared", {16'h0, if1.stall_cnt}, 32'h0);

        // First conflict after reset goes to requester 0 although it won last;
        // then hold both to saturate the stall counter.
        next();
        if1.req0_valid = 1'b1;
        if1.req1_valid = 1'b1;
        #1;
        chk("m_conflict_ready0", {31'h0, if1.req0_ready}, 32'h1);
        chk("m_conflict_ready1", {31'h0, if1.req1_ready}, 32'h0);
        for (int n = 1; n <= 70000; n++) begin
            next();
            #1;
            if (n == 1) begin
                chk("sat_alt_ready1", {31'h0, if1.req1_ready}, 32'h1);
            end
            if (n == 2) begin
                chk("sat_alt_ready0", {31'h0, if1.req0_ready}, 32'h1);
            end
            if (n == 1000) begin
                chk("sat_stall_1000", {16'h0, if1.stall_cnt}, 32'd1000);
            end
            if (n == 65534) begin
                chk("sat_stall_fffe", {16'h0, if1.stall_cnt}, 32'h0000_FFFE);
            end
            if (n == 65535) begin
                chk("sat_stall_ffff", {16'h0, if1.stall_cnt}, 32'h0000_FFFF);
            end
            if (n == 70000) begin
                chk("sat_stall_hold", {16'h0, if1.stall_cnt}, 32'h0000_FFFF);
            end
        end
        if1.req0_valid = 1'b0;
        if1.req1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
